// File: rtl/bsg_chip_pkg.sv
// Definitions shared between the core complex and the gateway link arbiter:
// header length field layout and the arbiter state encoding.
package bsg_chip_pkg;

  localparam int hdr_len_width_gp = 4;
  localparam int hdr_width_gp     = 64;

  // len counts the flits that follow the header (0 = single-flit packet)
  typedef struct packed {
    logic [hdr_width_gp-hdr_len_width_gp-1:0] payload;
    logic [hdr_len_width_gp-1:0]              len;
  } bsg_chip_hdr_s;

  typedef enum logic {
    e_idle = 1'b0,
    e_lock = 1'b1
  } arb_state_e;

endpackage

// File: rtl/bsg_gateway_chip_rr_pick.sv
// Round-robin picker: first requester after last_i (wrapping), as one-hot and index.
module bsg_gateway_chip_rr_pick #(
  parameter  int num_req_p = 4,
  localparam int lg_req_lp = $clog2(num_req_p)
) (
  input  logic [num_req_p-1:0] req_i,
  input  logic [lg_req_lp-1:0] last_i,
  output logic [num_req_p-1:0] grant_o,
  output logic [lg_req_lp-1:0] idx_o,
  output logic                 v_o
);

  int j;

  always_comb begin
    idx_o   = '0;
    v_o     = 1'b0;
    grant_o = '0;
    j       = 0;
    // search starts one past the previous winner and wraps
    for (int k = 1; k <= num_req_p; k++) begin
      j = int'(last_i) + k;
      if (j >= num_req_p) j = j - num_req_p;
      if (!v_o && req_i[lg_req_lp'(j)]) begin
        v_o   = 1'b1;
        idx_o = lg_req_lp'(j);
      end
    end
    if (v_o) grant_o[idx_o] = 1'b1;
  end

endmodule

// File: rtl/bsg_gateway_chip_link_arbiter.sv
// Shares one link transmit channel among num_req_p packet sources: round-robin
// between packets, locked to one owner for a whole packet, gated by remote credits.
module bsg_gateway_chip_link_arbiter
  import bsg_chip_pkg::*;
#(
  parameter  int num_req_p        = 4,
  parameter  int width_p          = 64,
  parameter  int len_width_p      = hdr_len_width_gp,
  parameter  int remote_credits_p = 16,
  localparam int lg_req_lp        = $clog2(num_req_p),
  localparam int cred_w_lp        = $clog2(remote_credits_p + 1)
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [num_req_p-1:0]              v_i,
  input  logic [num_req_p-1:0][width_p-1:0] data_i,
  output logic [num_req_p-1:0]              yumi_o,
  output logic                              v_o,
  output logic [width_p-1:0]                data_o,
  input  logic                              ready_i,
  input  logic                              credit_i,
  output logic [cred_w_lp-1:0]              credits_o,
  output logic                              busy_o
);

  localparam logic [cred_w_lp-1:0] rc_lp       = cred_w_lp'(remote_credits_p);
  localparam logic [lg_req_lp-1:0] last_rst_lp = lg_req_lp'(num_req_p - 1);

  arb_state_e               state_r, state_n;
  logic [lg_req_lp-1:0]     owner_r, last_r, pick_idx, gnt_idx;
  logic [len_width_p-1:0]   rem_r, hdr_len;
  logic [cred_w_lp-1:0]     credits_r;
  logic [num_req_p-1:0]     pick_grant;
  logic                     pick_v, send;

  bsg_gateway_chip_rr_pick #(.num_req_p(num_req_p)) pick (
    .req_i   (v_i),
    .last_i  (last_r),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .v_o     (pick_v)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= e_idle;
    else         state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    case (state_r)
      e_idle: if (send && hdr_len != '0)                state_n = e_lock;
      e_lock: if (send && rem_r == len_width_p'(1))     state_n = e_idle;
    endcase
  end

  // Zero-latency path: grant, valid and data are all combinational from the inputs.
  always_comb begin
    gnt_idx   = (state_r == e_lock) ? owner_r : pick_idx;
    v_o       = !reset_i && (credits_r != '0)
                && ((state_r == e_lock) ? v_i[owner_r] : pick_v);
    data_o    = data_i[gnt_idx];
    hdr_len   = data_o[len_width_p-1:0];
    send      = v_o & ready_i;
    yumi_o    = '0;
    if (send) begin
      if (state_r == e_lock) yumi_o[owner_r] = 1'b1;
      else                   yumi_o          = pick_grant;
    end
    busy_o    = !reset_i && (state_r == e_lock);
    credits_o = reset_i ? rc_lp : credits_r;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      owner_r <= '0;
      rem_r   <= '0;
      last_r  <= last_rst_lp;
    end else if (send) begin
      if (state_r == e_idle) begin
        last_r <= pick_idx;
        if (hdr_len != '0) begin
          owner_r <= pick_idx;
          rem_r   <= hdr_len;
        end
      end else begin
        rem_r <= rem_r - len_width_p'(1);
      end
    end
  end

  // A credit arriving together with a send cancels out.
  always_ff @(posedge clk_i) begin
    if (reset_i)                                        credits_r <= rc_lp;
    else if (send && !credit_i)                         credits_r <= credits_r - cred_w_lp'(1);
    else if (credit_i && !send && credits_r != rc_lp)   credits_r <= credits_r + cred_w_lp'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i)
      assert (!(credit_i && !send && credits_r == rc_lp))
        else $error("link arbiter: credit returned with counter already full");
  end

endmodule

// File: tb/tb_bsg_gateway_chip_link_arbiter.sv
// Directed bench for the gateway link arbiter with a queue of expected per-cycle outputs.
module tb_bsg_gateway_chip_link_arbiter;
  import bsg_chip_pkg::*;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int RC = 16;
  localparam int CW = 5;

  logic                clk = 1'b0;
  logic                reset;
  logic [N-1:0]        v;
  logic [N-1:0][W-1:0] data;
  logic [N-1:0]        yumi;
  logic                v_o;
  logic [W-1:0]        data_o;
  logic                ready, credit;
  logic [CW-1:0]       credits;
  logic                busy;

  always #5 clk = ~clk;

  bsg_gateway_chip_link_arbiter #(
    .num_req_p(N), .width_p(W), .len_width_p(hdr_len_width_gp), .remote_credits_p(RC)
  ) dut (
    .clk_i(clk), .reset_i(reset), .v_i(v), .data_i(data), .yumi_o(yumi),
    .v_o(v_o), .data_o(data_o), .ready_i(ready), .credit_i(credit),
    .credits_o(credits), .busy_o(busy)
  );

  typedef struct packed {
    logic          v;
    logic [N-1:0]  yumi;
    logic          busy;
    logic [CW-1:0] cred;
    logic [W-1:0]  data;
  } exp_s;

  exp_s       sb[$];
  int         vectors = 0, miscompares = 0;
  int         exp_cred = RC;
  int         seq = 0;
  bit         prev_send = 0, loopback = 0;
  logic [3:0] lens [N];

  function automatic logic [W-1:0] mk(input int i, input logic [3:0] len);
    bsg_chip_hdr_s h;
    h.payload = {28'(seq), 32'(i)};
    h.len     = len;
    return h;
  endfunction

  task automatic cmp(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s step %0d: got %0h want %0h", tag, seq, obs, exp);
    end
  endtask

  // One cycle: drive, queue expectation, compare at negedge, advance credit bookkeeping.
  task automatic step(input logic [N-1:0] vv, input logic rdy, input logic cr,
                      input logic ev, input int idx, input logic eb);
    exp_s e;
    logic snd;
    seq++;
    v      = vv;
    ready  = rdy;
    credit = loopback ? prev_send : cr;
    for (int i = 0; i < N; i++) data[i] = mk(i, lens[i]);
    snd    = ev & rdy;
    e.v    = ev;
    e.yumi = snd ? (4'b0001 << idx) : 4'b0000;
    e.busy = eb;
    e.cred = reset ? CW'(RC) : CW'(exp_cred);
    e.data = data[idx];
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    cmp("v_o", W'(v_o), W'(e.v));
    cmp("yumi_o", W'(yumi), W'(e.yumi));
    cmp("busy_o", W'(busy), W'(e.busy));
    cmp("credits_o", W'(credits), W'(e.cred));
    if (e.v) cmp("data_o", data_o, e.data);
    if (reset) begin
      exp_cred  = RC;
      prev_send = 0;
    end else begin
      if (snd && !credit)      exp_cred--;
      else if (credit && !snd) exp_cred++;
      prev_send = snd;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; v = '0; ready = 1'b1; credit = 1'b0; data = '0;
    for (int i = 0; i < N; i++) lens[i] = 4'd0;
    @(posedge clk); #1;
    step(4'hF, 1, 0, 0, 0, 0);
    step(4'hF, 1, 0, 0, 0, 0);
    reset = 1'b0;

    // round robin over single-flit packets, credits looped back
    loopback = 1;
    for (int k = 0; k < 8; k++) step(4'hF, 1, 0, 1, k % 4, 0);
    step(4'h0, 1, 0, 0, 0, 0);

    // req1 locks for a 4-flit packet; req0/req2 keep requesting
    lens[1] = 4'd3;
    step(4'h7, 1, 0, 1, 0, 0);
    step(4'h7, 1, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) step(4'h7, 1, 0, 1, 1, 1);
    step(4'h7, 1, 0, 1, 2, 0);
    lens[1] = 4'd0;
    step(4'h0, 1, 0, 0, 0, 0);

    // credit exhaustion, then a single returned credit
    loopback = 0;
    for (int k = 0; k < 16; k++) step(4'h1, 1, 0, 1, 0, 0);
    for (int k = 0; k < 4; k++)  step(4'h1, 1, 0, 0, 0, 0);
    step(4'h1, 1, 1, 0, 0, 0);
    step(4'h1, 1, 0, 1, 0, 0);
    step(4'h1, 1, 0, 0, 0, 0);

    // same-cycle send and credit at count 5
    for (int k = 0; k < 5; k++) step(4'h0, 1, 1, 0, 0, 0);
    step(4'h1, 1, 1, 1, 0, 0);
    step(4'h0, 1, 0, 0, 0, 0);

    // req3 locked for 6 flits with ready toggling and owner gaps
    loopback = 1;
    lens[3]  = 4'd5;
    step(4'h8, 1, 0, 1, 3, 0);
    step(4'hF, 0, 0, 1, 3, 1);
    step(4'hF, 1, 0, 1, 3, 1);
    step(4'h7, 0, 0, 0, 0, 1);
    step(4'h7, 1, 0, 0, 0, 1);
    for (int k = 0; k < 4; k++) begin
      step(4'hF, 0, 0, 1, 3, 1);
      step(4'hF, 1, 0, 1, 3, 1);
    end
    step(4'hF, 1, 0, 1, 0, 0);
    lens[3] = 4'd0;

    // reset in the middle of a locked packet
    lens[1] = 4'd3;
    step(4'h2, 1, 0, 1, 1, 0);
    step(4'h2, 1, 0, 1, 1, 1);
    reset = 1'b1;
    step(4'hF, 1, 0, 0, 0, 0);
    reset = 1'b0;
    step(4'hF, 1, 0, 1, 0, 0);
    step(4'hF, 1, 0, 1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
